mac_tx: RTL and testbench

Ethernet MAC transmit framer; the transmit-side counterpart of `mac_rx`. It accepts one frame request from the upper-layer TX arbiter (`arp_tx`/`ip_tx`) and serializes it byte by byte into the eth TX data FIFO. Each frame is: 7×0x55 preamble, 0xD5 SFD, destination MAC, source MAC, EtherType, payload, zero pad, and CRC-32 FCS. Once the last FCS byte is written, the block pushes the total frame length into the eth TX length FIFO, so a downstream reader never sees a length before its data is complete.

---
 rtl/mac_tx_if.sv | 37 +++
 rtl/mac_tx.sv | 149 ++++++++++++++
 tb/tb_mac_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_if.sv
// Request, payload and FIFO-write bundle for the Ethernet MAC transmit framer.
// The slave modport is the framer. The master modport is the upper-layer arbiter
// and the FIFO side.
interface mac_tx_if #(
  parameter int LEN_W = 14
);
  logic             i_tx_req;
  logic [47:0]      i_dst_mac;
  logic [15:0]      i_eth_type;
  logic [LEN_W-1:0] i_payload_len;
  logic             i_payload_valid;
  logic [7:0]       i_payload_data;
  logic             o_payload_ready;
  logic             o_tx_busy;
  logic             o_tx_done;
  logic             o_tx_drop;
  logic             i_data_fifo_full;
  logic             o_data_fifo_w_en;
  logic [7:0]       o_data_fifo_w_data;
  logic             i_len_fifo_full;
  logic             o_len_fifo_w_en;
  logic [LEN_W-1:0] o_len_fifo_w_data;

  modport slave (
    input  i_tx_req, i_dst_mac, i_eth_type, i_payload_len,
    input  i_payload_valid, i_payload_data, i_data_fifo_full, i_len_fifo_full,
    output o_payload_ready, o_tx_busy, o_tx_done, o_tx_drop,
    output o_data_fifo_w_en, o_data_fifo_w_data, o_len_fifo_w_en, o_len_fifo_w_data
  );

  modport master (
    output i_tx_req, i_dst_mac, i_eth_type, i_payload_len,
    output i_payload_valid, i_payload_data, i_data_fifo_full, i_len_fifo_full,
    input  o_payload_ready, o_tx_busy, o_tx_done, o_tx_drop,
    input  o_data_fifo_w_en, o_data_fifo_w_data, o_len_fifo_w_en, o_len_fifo_w_data
  );
endinterface

// File: rtl/mac_tx.sv
// Ethernet MAC transmit framer. It serializes preamble/SFD, header, payload, zero
// pad and the CRC-32 FCS into the TX data FIFO, one byte per cycle. After the
// last FCS byte it pushes the total frame length into the TX length FIFO.
module mac_tx #(
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_01_02,
  parameter int          LEN_W       = 14,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic    i_sys_clk,
  input  logic    i_rstn,
  mac_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, LEN} state_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PAYLOAD);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1500);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      crc;
  logic             drop;
  logic [47:0]      dst_mac;
  logic [15:0]      eth_type;
  logic [LEN_W-1:0] pay_len, pad_len, frame_len;
  logic [LEN_W-1:0] pay_eff;
  logic             accept, reject, wr, ready;
  logic [7:0]       byte_out;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Request qualification: oversize requests are rejected, never accepted
  always_comb begin
    pay_eff = (bus.i_payload_len < MIN_LEN) ? MIN_LEN : bus.i_payload_len;
    reject  = (state == IDLE) && bus.i_tx_req && (bus.i_payload_len > MAX_LEN);
    accept  = (state == IDLE) && bus.i_tx_req && !bus.i_len_fifo_full &&
              !(bus.i_payload_len > MAX_LEN);
  end

  // Next state and byte selection; any write advances the counter
  always_comb begin
    state_nxt = state;
    byte_out  = 8'h00;
    wr        = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = PREAMBLE;
      PREAMBLE: begin
        wr       = !bus.i_data_fifo_full;
        byte_out = (cnt == LEN_W'(7)) ? 8'hD5 : 8'h55;
        if (wr && cnt == LEN_W'(7)) state_nxt = HEADER;
      end
      HEADER: begin
        wr = !bus.i_data_fifo_full;
        case (cnt[3:0])
          4'd0:    byte_out = dst_mac[47:40];
          4'd1:    byte_out = dst_mac[39:32];
          4'd2:    byte_out = dst_mac[31:24];
          4'd3:    byte_out = dst_mac[23:16];
          4'd4:    byte_out = dst_mac[15:8];
          4'd5:    byte_out = dst_mac[7:0];
          4'd6:    byte_out = SRC_MAC[47:40];
          4'd7:    byte_out = SRC_MAC[39:32];
          4'd8:    byte_out = SRC_MAC[31:24];
          4'd9:    byte_out = SRC_MAC[23:16];
          4'd10:   byte_out = SRC_MAC[15:8];
          4'd11:   byte_out = SRC_MAC[7:0];
          4'd12:   byte_out = eth_type[15:8];
          default: byte_out = eth_type[7:0];
        endcase
        if (wr && cnt == LEN_W'(13))
          state_nxt = (pay_len != '0) ? PAYLOAD : ((pad_len != '0) ? PAD : FCS);
      end
      PAYLOAD: begin
        ready    = !bus.i_data_fifo_full;
        wr       = bus.i_payload_valid && !bus.i_data_fifo_full;
        byte_out = bus.i_payload_data;
        if (wr && (cnt + ONE) == pay_len) state_nxt = (pad_len != '0) ? PAD : FCS;
      end
      PAD: begin
        wr = !bus.i_data_fifo_full;
        if (wr && (cnt + ONE) == pad_len) state_nxt = FCS;
      end
      FCS: begin
        wr = !bus.i_data_fifo_full;
        case (cnt[1:0])
          2'd0:    byte_out = ~crc[7:0];
          2'd1:    byte_out = ~crc[15:8];
          2'd2:    byte_out = ~crc[23:16];
          default: byte_out = ~crc[31:24];
        endcase
        if (wr && cnt == LEN_W'(3)) state_nxt = LEN;
      end
      LEN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Byte counter, running CRC and drop pulse; all hold while the data FIFO is full
  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt  <= '0;
      crc  <= 32'hFFFF_FFFF;
      drop <= 1'b0;
    end else begin
      drop <= reject;
      if (state_nxt != state) cnt <= '0;
      else if (wr)            cnt <= cnt + ONE;
      if (state == PREAMBLE && state_nxt == HEADER)
        crc <= 32'hFFFF_FFFF;
      else if (wr && (state inside {HEADER, PAYLOAD, PAD}))
        crc <= crc_byte(crc, byte_out);
    end
  end

  // Request fields captured at acceptance; they are only read while busy
  always_ff @(posedge i_sys_clk) begin
    if (accept) begin
      dst_mac   <= bus.i_dst_mac;
      eth_type  <= bus.i_eth_type;
      pay_len   <= bus.i_payload_len;
      pad_len   <= pay_eff - bus.i_payload_len;
      frame_len <= pay_eff + LEN_W'(26);
    end
  end

  assign bus.o_payload_ready    = ready;
  assign bus.o_data_fifo_w_en   = wr;
  assign bus.o_data_fifo_w_data = wr ? byte_out : 8'h00;
  assign bus.o_tx_busy          = (state != IDLE);
  assign bus.o_tx_done          = (state == LEN);
  assign bus.o_len_fifo_w_en    = (state == LEN);
  assign bus.o_len_fifo_w_data  = (state == LEN) ? frame_len : '0;
  assign bus.o_tx_drop          = drop;

endmodule

// File: tb/tb_mac_tx.sv
// Directed bench for mac_tx. Each task drives one scenario and checks the captured
// byte stream, length FIFO pushes and pulses against hand-derived values.
module tb_mac_tx;
  localparam logic [47:0] SRC = 48'h00_1A_2B_3C_4D_5E;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mac_tx_if #(.LEN_W(14)) bus();
  mac_tx #(.SRC_MAC(SRC), .LEN_W(14), .MIN_PAYLOAD(46)) dut (
    .i_sys_clk(clk), .i_rstn(rstn), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] bytes[$];
  logic [7:0] ref_q[$];
  int len_q[$];
  int done_cnt, drop_cnt, busy_cnt, done_cyc, acc, ref_rel;
  logic [7:0] pay_mem[0:1599];
  int pay_n, pay_idx;
  bit pay_toggle, phase, pay_take, stall_en;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample outputs on the falling edge
  always @(negedge clk) begin
    pay_take = bus.i_payload_valid && bus.o_payload_ready;
    if (bus.o_data_fifo_w_en) bytes.push_back(bus.o_data_fifo_w_data);
    if (bus.o_len_fifo_w_en) len_q.push_back(int'(bus.o_len_fifo_w_data));
    if (bus.o_tx_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.o_tx_drop) drop_cnt++;
    if (bus.o_tx_busy) busy_cnt++;
  end

  // Payload source and data-FIFO stall pattern, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pay_take) pay_idx++;
    phase = ~phase;
    bus.i_payload_valid = (pay_idx < pay_n) && (!pay_toggle || phase);
    bus.i_payload_data  = pay_mem[(pay_idx < 1600) ? pay_idx : 0];
    bus.i_data_fifo_full = stall_en && (acc >= 0) &&
      (((cyc - acc) >= 12 && (cyc - acc) <= 16) || ((cyc - acc) >= 40 && (cyc - acc) <= 42));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] residue(input int from);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < bytes.size(); i++) begin
      c = c ^ {24'h0, bytes[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Mismatches over everything except the FCS (which the residue covers)
  function automatic int body_errs(input int len, input logic [47:0] dst,
                                   input logic [15:0] typ, input int flen);
    int errs;
    logic [7:0] e;
    errs = 0;
    for (int i = 0; i < flen - 4; i++) begin
      if (i < 7)       e = 8'h55;
      else if (i == 7) e = 8'hD5;
      else if (i < 14) e = dst[8*(13-i) +: 8];
      else if (i < 20) e = SRC[8*(19-i) +: 8];
      else if (i == 20) e = typ[15:8];
      else if (i == 21) e = typ[7:0];
      else if (i - 22 < len) e = pay_mem[i-22];
      else e = 8'h00;
      if (i >= bytes.size()) errs++;
      else if (bytes[i] !== e) errs++;
    end
    return errs;
  endfunction

  function automatic int first_len();
    return (len_q.size() == 1) ? len_q[0] : -1;
  endfunction

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                            input int len, output bit ok);
    @(posedge clk); #1;
    bytes.delete(); len_q.delete();
    done_cnt = 0; drop_cnt = 0; busy_cnt = 0; acc = -1;
    pay_n = len; pay_idx = 0;
    bus.i_dst_mac = dst; bus.i_eth_type = typ; bus.i_payload_len = 14'(len);
    bus.i_tx_req = 1'b1;
    for (int i = 0; i < 100 && acc < 0; i++) begin
      @(posedge clk); #1;
      if (bus.o_tx_busy) acc = cyc;
    end
    bus.i_tx_req = 1'b0;
    if (acc >= 0)
      for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    ok = (done_cnt != 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({bus.o_tx_busy, bus.o_tx_done, bus.o_tx_drop, bus.o_data_fifo_w_en,
         bus.o_len_fifo_w_en, bus.o_payload_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 000000",
        {bus.o_tx_busy, bus.o_tx_done, bus.o_tx_drop, bus.o_data_fifo_w_en,
         bus.o_len_fifo_w_en, bus.o_payload_ready});
    end
    n_checks++;
    if ({bus.o_data_fifo_w_data, bus.o_len_fifo_w_data} !== 22'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h, expected 0/0",
        bus.o_data_fifo_w_data, bus.o_len_fifo_w_data);
    end
    rstn = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({bus.o_tx_busy, bus.o_data_fifo_w_en, bus.o_len_fifo_w_en} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, expected 000",
        {bus.o_tx_busy, bus.o_data_fifo_w_en, bus.o_len_fifo_w_en});
    end
  endtask

  task automatic test_min_frame();
    bit ok;
    send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL min_done: got %0d, expected 1", ok); end
    n_checks++;
    if (bytes.size() !== 72) begin
      n_fail++; $display("FAIL min_bytes: got %0d, expected 72", bytes.size());
    end
    n_checks++;
    if (body_errs(0, 48'hFFFF_FFFF_FFFF, 16'h0806, 72) !== 0) begin
      n_fail++; $display("FAIL min_body: got %0d bad bytes, expected 0",
        body_errs(0, 48'hFFFF_FFFF_FFFF, 16'h0806, 72));
    end
    n_checks++;
    if (residue(8) !== 32'hDEBB20E3) begin
      n_fail++; $display("FAIL min_crc: got %h, expected deb b20e3", residue(8));
    end
    n_checks++;
    if (first_len() !== 72) begin
      n_fail++; $display("FAIL min_len: got %0d, expected 72", first_len());
    end
    n_checks++;
    if (done_cyc - acc + 1 !== 73) begin
      n_fail++; $display("FAIL min_done_cycle: got %0d, expected 73", done_cyc - acc + 1);
    end
  endtask

  task automatic test_len100();
    bit ok;
    for (int k = 0; k < 100; k++) pay_mem[k] = 8'(k);
    send_frame(48'h0011_2233_4455, 16'h0800, 100, ok);
    n_checks++;
    if ({ok, 32'(bytes.size())} !== {1'b1, 32'd126}) begin
      n_fail++; $display("FAIL p100_bytes: got done=%0d n=%0d, expected done=1 n=126", ok, bytes.size());
    end
    n_checks++;
    if (body_errs(100, 48'h0011_2233_4455, 16'h0800, 126) !== 0) begin
      n_fail++; $display("FAIL p100_body: got %0d bad bytes, expected 0",
        body_errs(100, 48'h0011_2233_4455, 16'h0800, 126));
    end
    n_checks++;
    if (residue(8) !== 32'hDEBB20E3) begin
      n_fail++; $display("FAIL p100_crc: got %h, expected debb20e3", residue(8));
    end
    n_checks++;
    if (first_len() !== 126) begin
      n_fail++; $display("FAIL p100_len: got %0d, expected 126", first_len());
    end
    ref_q = bytes;
    ref_rel = done_cyc - acc + 1;
    n_checks++;
    if (ref_rel !== 127) begin
      n_fail++; $display("FAIL p100_done_cycle: got %0d, expected 127", ref_rel);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int diffs;
    stall_en = 1'b1;
    send_frame(48'h0011_2233_4455, 16'h0800, 100, ok);
    stall_en = 1'b0;
    diffs = (bytes.size() == ref_q.size()) ? 0 : 1;
    for (int i = 0; i < bytes.size() && i < ref_q.size(); i++)
      if (bytes[i] !== ref_q[i]) diffs++;
    n_checks++;
    if ({ok, 32'(diffs)} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL stall_stream: got done=%0d diffs=%0d, expected done=1 diffs=0", ok, diffs);
    end
    n_checks++;
    if (done_cyc - acc + 1 !== 135) begin
      n_fail++; $display("FAIL stall_done_cycle: got %0d, expected 135", done_cyc - acc + 1);
    end
  endtask

  task automatic test_valid_toggle();
    bit ok;
    for (int k = 0; k < 60; k++) pay_mem[k] = 8'(k) ^ 8'hA5;
    pay_toggle = 1'b1;
    fork
      send_frame(48'hA1A2_A3A4_A5A6, 16'h86DD, 60, ok);
      begin
        repeat (40) @(negedge clk);
        bus.i_len_fifo_full = 1'b1;
      end
    join
    bus.i_len_fifo_full = 1'b0;
    pay_toggle = 1'b0;
    n_checks++;
    if ({ok, 32'(bytes.size())} !== {1'b1, 32'd86}) begin
      n_fail++; $display("FAIL toggle_bytes: got done=%0d n=%0d, expected done=1 n=86", ok, bytes.size());
    end
    n_checks++;
    if (body_errs(60, 48'hA1A2_A3A4_A5A6, 16'h86DD, 86) !== 0) begin
      n_fail++; $display("FAIL toggle_body: got %0d bad bytes, expected 0",
        body_errs(60, 48'hA1A2_A3A4_A5A6, 16'h86DD, 86));
    end
    n_checks++;
    if ({residue(8), 32'(first_len())} !== {32'hDEBB20E3, 32'd86}) begin
      n_fail++; $display("FAIL toggle_crc_len: got %h/%0d, expected debb20e3/86", residue(8), first_len());
    end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    bytes.delete(); len_q.delete(); drop_cnt = 0; busy_cnt = 0;
    bus.i_payload_len = 14'd1501; bus.i_tx_req = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_req = 1'b0;
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if (drop_cnt !== 1) begin n_fail++; $display("FAIL drop_pulse: got %0d, expected 1", drop_cnt); end
    n_checks++;
    if ({32'(bytes.size()), 32'(busy_cnt), 32'(len_q.size())} !== 96'h0) begin
      n_fail++; $display("FAIL drop_quiet: got bytes=%0d busy=%0d lens=%0d, expected 0/0/0",
        bytes.size(), busy_cnt, len_q.size());
    end
  endtask

  task automatic test_len_full();
    bit ok;
    int early;
    early = 0;
    bus.i_len_fifo_full = 1'b1;
    fork
      send_frame(48'h0102_0304_0506, 16'h0806, 10, ok);
      begin
        repeat (8) begin @(negedge clk); if (bus.o_tx_busy) early++; end
        bus.i_len_fifo_full = 1'b0;
      end
    join
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL lenfull_hold: got %0d busy cycles, expected 0", early); end
    n_checks++;
    if ({ok, 32'(bytes.size()), 32'(first_len())} !== {1'b1, 32'd72, 32'd72}) begin
      n_fail++; $display("FAIL lenfull_frame: got done=%0d n=%0d len=%0d, expected 1/72/72",
        ok, bytes.size(), first_len());
    end
  endtask

  task automatic test_max();
    bit ok;
    for (int k = 0; k < 1500; k++) pay_mem[k] = 8'(k * 7);
    send_frame(48'h5A5A_5A5A_5A5A, 16'h0800, 1500, ok);
    n_checks++;
    if ({ok, 32'(bytes.size()), 32'(first_len())} !== {1'b1, 32'd1526, 32'd1526}) begin
      n_fail++; $display("FAIL max_frame: got done=%0d n=%0d len=%0d, expected 1/1526/1526",
        ok, bytes.size(), first_len());
    end
    n_checks++;
    if (body_errs(1500, 48'h5A5A_5A5A_5A5A, 16'h0800, 1526) !== 0 || residue(8) !== 32'hDEBB20E3) begin
      n_fail++; $display("FAIL max_content: got %0d bad bytes crc %h, expected 0 debb20e3",
        body_errs(1500, 48'h5A5A_5A5A_5A5A, 16'h0800, 1526), residue(8));
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    for (int k = 0; k < 60; k++) pay_mem[k] = 8'(k + 3);
    @(posedge clk); #1;
    bytes.delete(); len_q.delete(); done_cnt = 0; acc = -1;
    pay_n = 60; pay_idx = 0;
    bus.i_dst_mac = 48'h0A0B_0C0D_0E0F; bus.i_eth_type = 16'h0800;
    bus.i_payload_len = 14'd60; bus.i_tx_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (bus.o_tx_busy) bus.i_tx_req = 1'b0;
      if (bytes.size() >= 32) hit = 1'b1;
    end
    bus.i_tx_req = 1'b0;
    n_checks++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: got %0d bytes, expected 32", bytes.size()); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_tx_busy, bus.o_data_fifo_w_en, bus.o_payload_ready, bus.o_len_fifo_w_en,
         bus.o_tx_done, bus.o_data_fifo_w_data} !== 13'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%0d wen=%0d rdy=%0d, expected 0",
        bus.o_tx_busy, bus.o_data_fifo_w_en, bus.o_payload_ready);
    end
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    n_checks++;
    if ({32'(done_cnt), 32'(len_q.size())} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_nolen: got done=%0d lens=%0d, expected 0/0", done_cnt, len_q.size());
    end
    send_frame(48'h0A0B_0C0D_0E0F, 16'h0800, 20, ok);
    n_checks++;
    if ({ok, 32'(bytes.size()), 32'(first_len()), residue(8)} !==
        {1'b1, 32'd72, 32'd72, 32'hDEBB20E3}) begin
      n_fail++; $display("FAIL rstmid_next: got done=%0d n=%0d len=%0d crc=%h, expected 1/72/72/debb20e3",
        ok, bytes.size(), first_len(), residue(8));
    end
    n_checks++;
    if (body_errs(20, 48'h0A0B_0C0D_0E0F, 16'h0800, 72) !== 0) begin
      n_fail++; $display("FAIL rstmid_body: got %0d bad bytes, expected 0",
        body_errs(20, 48'h0A0B_0C0D_0E0F, 16'h0800, 72));
    end
  endtask

  initial begin
    bus.i_tx_req = 1'b0; bus.i_dst_mac = '0; bus.i_eth_type = '0; bus.i_payload_len = '0;
    bus.i_payload_valid = 1'b0; bus.i_payload_data = '0;
    bus.i_data_fifo_full = 1'b0; bus.i_len_fifo_full = 1'b0;
    pay_n = 0; pay_idx = 0; pay_toggle = 1'b0; phase = 1'b0; pay_take = 1'b0;
    stall_en = 1'b0; acc = -1; done_cnt = 0; drop_cnt = 0; busy_cnt = 0; done_cyc = 0;
    test_reset();
    test_min_frame();
    test_len100();
    test_stall();
    test_valid_toggle();
    test_drop();
    test_len_full();
    test_max();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
